// File: rtl/clock_ctrl_if.sv
// Key inputs and counter/display outputs of the time-counter sequencer.
// slave: the sequencer side; master: the board/display side.
interface clock_ctrl_if;
   logic       key_mode;
   logic       key_inc;
   logic       cnt_clk;
   logic       stop;
   logic       adjust_h;
   logic       adjust_m;
   logic       adjust_s;
   logic [1:0] field_sel;
   logic       blink;

   modport master (
      output key_mode, key_inc,
      input  cnt_clk, stop, adjust_h, adjust_m, adjust_s,
      input  field_sel, blink
   );

   modport slave (
      input  key_mode, key_inc,
      output cnt_clk, stop, adjust_h, adjust_m, adjust_s,
      output field_sel, blink
   );
endinterface

// File: rtl/clock_ctrl.sv
// Sequencer for a 24 h time counter: 1 Hz tick, key debounce, set-mode FSM.
// Ports: clk, rst (sync, active-high), bus (clock_ctrl_if.slave: keys in,
// cnt_clk/stop/adjust_*/field_sel/blink out).
module clock_ctrl #(
   parameter int CLK_HZ        = 50000000,
   parameter int DB_CYCLES     = 500000,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   clock_ctrl_if.slave bus
);
   localparam int PW   = $clog2(CLK_HZ + 1);
   localparam int DW   = $clog2(DB_CYCLES + 1);
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
   localparam int BW   = $clog2(HALF + 1);

   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);
   localparam logic [RW-1:0] HOLD_L  = RW'(HOLD_CYCLES);
   localparam logic [RW-1:0] REP_L   = RW'(REPEAT_CYCLES);
   localparam logic [BW-1:0] BL_MAX  = BW'(HALF - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   // index 0 = mode key, index 1 = inc key
   logic [1:0]         key_raw;
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         db_q, db_dly_q;
   logic [1:0][DW-1:0] dbc_q;
   logic               mode_p, inc_p;

   state_t             state_q, state_d;
   logic [PW-1:0]      pre_q;
   logic [RW-1:0]      rep_q;
   logic               rep_on_q, rep_first_q;
   logic [BW-1:0]      bl_q;
   logic               run, wrap, rep_fire, inc_ev;

   logic               cnt_clk_q, stop_q, blink_q;
   logic               adj_h_q, adj_m_q, adj_s_q;
   logic [1:0]         fsel_q;

   assign key_raw = {bus.key_inc, bus.key_mode};

   // Debounce: level follows the synchronized key only after it has
   // disagreed for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         db_dly_q <= '0;
         dbc_q    <= '0;
      end else begin
         sync1_q  <= key_raw;
         sync2_q  <= sync1_q;
         db_dly_q <= db_q;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == db_q[k]) begin
               dbc_q[k] <= '0;
            end else if (dbc_q[k] == DB_MAX) begin
               db_q[k]  <= sync2_q[k];
               dbc_q[k] <= '0;
            end else begin
               dbc_q[k] <= dbc_q[k] + 1'b1;
            end
         end
      end
   end

   assign mode_p = db_q[0] & ~db_dly_q[0];
   assign inc_p  = db_q[1] & ~db_dly_q[1];

   assign run      = (state_q == RUN);
   assign wrap     = (pre_q == PRE_MAX);
   assign rep_fire = rep_on_q && db_q[1] &&
                     (rep_q == (rep_first_q ? HOLD_L : REP_L));
   // A mode press in the same cycle swallows any inc activity.
   assign inc_ev   = !run && !mode_p && (inc_p || rep_fire);

   always_comb begin
      state_d = state_q;
      if (mode_p) state_d = state_t'(state_q + 2'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pre_q       <= '0;
         rep_q       <= '0;
         rep_on_q    <= 1'b0;
         rep_first_q <= 1'b0;
         bl_q        <= '0;
         cnt_clk_q   <= 1'b0;
         stop_q      <= 1'b0;
         adj_h_q     <= 1'b0;
         adj_m_q     <= 1'b0;
         adj_s_q     <= 1'b0;
         fsel_q      <= 2'd0;
         blink_q     <= 1'b1;
      end else begin
         state_q <= state_d;
         stop_q  <= (state_d != RUN);
         adj_h_q <= (state_d == SET_H);
         adj_m_q <= (state_d == SET_M);
         adj_s_q <= (state_d == SET_S);
         fsel_q  <= state_d;

         cnt_clk_q <= !mode_p && (run ? wrap : (inc_p || rep_fire));

         // Restart on return to RUN so the first second is whole.
         if ((mode_p && state_q == SET_S) || wrap) pre_q <= '0;
         else                                      pre_q <= pre_q + 1'b1;

         if (mode_p || run || !db_q[1]) begin
            rep_on_q <= 1'b0;
            rep_q    <= '0;
         end else if (inc_p) begin
            rep_on_q    <= 1'b1;
            rep_first_q <= 1'b1;
            rep_q       <= RW'(1);
         end else if (rep_fire) begin
            rep_first_q <= 1'b0;
            rep_q       <= RW'(1);
         end else if (rep_on_q) begin
            rep_q <= rep_q + 1'b1;
         end

         // Keep the field lit while it is being adjusted.
         if (state_d == RUN || mode_p || inc_ev) begin
            blink_q <= 1'b1;
            bl_q    <= '0;
         end else if (bl_q == BL_MAX) begin
            blink_q <= ~blink_q;
            bl_q    <= '0;
         end else begin
            bl_q <= bl_q + 1'b1;
         end
      end
   end

   assign bus.cnt_clk   = cnt_clk_q;
   assign bus.stop      = stop_q;
   assign bus.adjust_h  = adj_h_q;
   assign bus.adjust_m  = adj_m_q;
   assign bus.adjust_s  = adj_s_q;
   assign bus.field_sel = fsel_q;
   assign bus.blink     = blink_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed testbench for clock_ctrl with small timing parameters.
// Drives keys/reset on the falling edge and samples outputs there.
module tb_clock_ctrl;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   clock_ctrl_if bus ();

   clock_ctrl #(
      .CLK_HZ        (10),
      .DB_CYCLES     (3),
      .HOLD_CYCLES   (20),
      .REPEAT_CYCLES (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the falling edge where the new state is first visible.
   task automatic press_mode();
      bus.key_mode = 1'b1;
      idle(6);
      bus.key_mode = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
      idle(2);
      total++;
      if (bus.cnt_clk !== 1'b0) begin
         bad++; $display("FAIL rst_cnt_clk got=%b want=0", bus.cnt_clk);
      end
      total++;
      if (bus.stop !== 1'b0) begin
         bad++; $display("FAIL rst_stop got=%b want=0", bus.stop);
      end
      total++;
      if ({bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b000) begin
         bad++; $display("FAIL rst_adjust got=%b want=000",
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s});
      end
      total++;
      if (bus.field_sel !== 2'd0) begin
         bad++; $display("FAIL rst_fsel got=%0d want=0", bus.field_sel);
      end
      total++;
      if (bus.blink !== 1'b1) begin
         bad++; $display("FAIL rst_blink got=%b want=1", bus.blink);
      end
      rst = 1'b0;
   endtask

   task automatic test_run();
      logic exp;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         exp = (k % 10 == 0);
         total++;
         if (bus.cnt_clk !== exp) begin
            bad++; $display("FAIL run_tick k=%0d got=%b want=%b",
                            k, bus.cnt_clk, exp);
         end
         total++;
         if ({bus.stop, bus.adjust_h, bus.adjust_m, bus.adjust_s,
              bus.blink} !== 5'b00001) begin
            bad++; $display("FAIL run_ctrl k=%0d got=%b want=00001", k,
                            {bus.stop, bus.adjust_h, bus.adjust_m,
                             bus.adjust_s, bus.blink});
         end
      end
   endtask

   task automatic test_debounce();
      bus.key_mode = 1'b1;
      idle(2);
      bus.key_mode = 1'b0;
      idle(8);
      total++;
      if (bus.field_sel !== 2'd0 || bus.stop !== 1'b0) begin
         bad++; $display("FAIL db_glitch fsel=%0d stop=%b want 0/0",
                         bus.field_sel, bus.stop);
      end
      bus.key_mode = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 5) begin
            total++;
            if (bus.field_sel !== 2'd0) begin
               bad++; $display("FAIL db_early got=%0d want=0", bus.field_sel);
            end
         end
      end
      total++;
      if (bus.field_sel !== 2'd1 || bus.stop !== 1'b1) begin
         bad++; $display("FAIL db_press fsel=%0d stop=%b want 1/1",
                         bus.field_sel, bus.stop);
      end
      total++;
      if ({bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b100) begin
         bad++; $display("FAIL db_adj got=%b want=100",
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s});
      end
      bus.key_mode = 1'b0;
      idle(2);
      bus.key_mode = 1'b1;
      idle(1);
      bus.key_mode = 1'b0;
      idle(2);
      bus.key_mode = 1'b1;
      idle(1);
      bus.key_mode = 1'b0;
      idle(10);
      total++;
      if (bus.field_sel !== 2'd1) begin
         bad++; $display("FAIL db_bounce got=%0d want=1", bus.field_sel);
      end
   endtask

   task automatic test_cycle();
      logic exp;
      press_mode();
      total++;
      if (bus.field_sel !== 2'd2 ||
          {bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b010) begin
         bad++; $display("FAIL cyc_setm fsel=%0d adj=%b want 2/010",
                         bus.field_sel,
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s});
      end
      idle(8);
      press_mode();
      total++;
      if (bus.field_sel !== 2'd3 ||
          {bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b001) begin
         bad++; $display("FAIL cyc_sets fsel=%0d adj=%b want 3/001",
                         bus.field_sel,
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s});
      end
      idle(8);
      press_mode();
      total++;
      if (bus.field_sel !== 2'd0 || bus.stop !== 1'b0 ||
          {bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b000 ||
          bus.cnt_clk !== 1'b0) begin
         bad++; $display("FAIL cyc_run fsel=%0d stop=%b adj=%b cnt=%b want 0/0/000/0",
                         bus.field_sel, bus.stop,
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s},
                         bus.cnt_clk);
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp = (k == 10);
         total++;
         if (bus.cnt_clk !== exp) begin
            bad++; $display("FAIL cyc_first_tick k=%0d got=%b want=%b",
                            k, bus.cnt_clk, exp);
         end
      end
   endtask

   task automatic test_inc();
      int   npulse;
      int   nall;
      logic exp;
      idle(2);
      press_mode();
      idle(8);
      press_mode();
      idle(8);
      nall = 0;
      for (int i = 0; i < 3; i++) begin
         bus.key_inc = 1'b1;
         idle(5);
         total++;
         if (bus.cnt_clk !== 1'b0) begin
            bad++; $display("FAIL inc_early i=%0d got=%b want=0",
                            i, bus.cnt_clk);
         end
         idle(1);
         if (bus.cnt_clk === 1'b1) nall++;
         total++;
         if (bus.cnt_clk !== 1'b1 || bus.adjust_m !== 1'b1 ||
             bus.blink !== 1'b1) begin
            bad++; $display("FAIL inc_pulse i=%0d cnt=%b adjm=%b blink=%b want 1/1/1",
                            i, bus.cnt_clk, bus.adjust_m, bus.blink);
         end
         bus.key_inc = 1'b0;
         npulse = 0;
         for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus.cnt_clk === 1'b1) npulse++;
         end
         nall += npulse;
         total++;
         if (npulse !== 0) begin
            bad++; $display("FAIL inc_extra i=%0d got=%0d want=0", i, npulse);
         end
      end
      total++;
      if (nall !== 3) begin
         bad++; $display("FAIL inc_count got=%0d want=3", nall);
      end
      press_mode();
      idle(8);
      press_mode();
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         exp = (k % 10 == 0);
         total++;
         if (bus.cnt_clk !== exp) begin
            bad++; $display("FAIL inc_run k=%0d got=%b want=%b",
                            k, bus.cnt_clk, exp);
         end
         if (k == 3) bus.key_inc = 1'b1;
         if (k == 9) bus.key_inc = 1'b0;
      end
   endtask

   task automatic test_autorepeat();
      logic exp;
      idle(8);
      press_mode();
      idle(8);
      press_mode();
      idle(8);
      press_mode();
      idle(8);
      total++;
      if (bus.field_sel !== 2'd3) begin
         bad++; $display("FAIL rep_state got=%0d want=3", bus.field_sel);
      end
      bus.key_inc = 1'b1;
      for (int j = 1; j <= 75; j++) begin
         @(negedge clk);
         exp = (j == 6) || (j == 26) ||
               (j >= 31 && j <= 51 && (j - 26) % 5 == 0);
         total++;
         if (bus.cnt_clk !== exp) begin
            bad++; $display("FAIL rep_hold j=%0d got=%b want=%b",
                            j, bus.cnt_clk, exp);
         end
         if (j == 26) begin
            total++;
            if (bus.blink !== 1'b1 || bus.adjust_s !== 1'b1) begin
               bad++; $display("FAIL rep_blink blink=%b adjs=%b want 1/1",
                               bus.blink, bus.adjust_s);
            end
         end
         if (j == 50) bus.key_inc = 1'b0;
      end
      bus.key_inc = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         exp = (j == 6) || (j == 26) || (j == 31) ||
               (j == 44) || (j == 54);
         total++;
         if (bus.cnt_clk !== exp) begin
            bad++; $display("FAIL rep_mode j=%0d got=%b want=%b",
                            j, bus.cnt_clk, exp);
         end
         if (j == 28) bus.key_mode = 1'b1;
         if (j == 34) bus.key_mode = 1'b0;
         if (j == 50) bus.key_inc  = 1'b0;
      end
      total++;
      if (bus.field_sel !== 2'd0) begin
         bad++; $display("FAIL rep_mode_state got=%0d want=0", bus.field_sel);
      end
   endtask

   task automatic test_simul();
      logic exp;
      press_mode();
      idle(8);
      bus.key_mode = 1'b1;
      bus.key_inc  = 1'b1;
      for (int j = 1; j <= 22; j++) begin
         @(negedge clk);
         total++;
         if (bus.cnt_clk !== 1'b0) begin
            bad++; $display("FAIL sim_cnt j=%0d got=%b want=0",
                            j, bus.cnt_clk);
         end
         if (j == 6) begin
            total++;
            if (bus.field_sel !== 2'd2 ||
                {bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b010) begin
               bad++; $display("FAIL sim_state fsel=%0d adj=%b want 2/010",
                               bus.field_sel,
                               {bus.adjust_h, bus.adjust_m, bus.adjust_s});
            end
            bus.key_mode = 1'b0;
            bus.key_inc  = 1'b0;
         end
         if (j >= 6) begin
            exp = (((j - 6) / 5) % 2 == 0);
            total++;
            if (bus.blink !== exp) begin
               bad++; $display("FAIL sim_blink j=%0d got=%b want=%b",
                               j, bus.blink, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.key_mode = 1'b1;
      rst = 1'b1;
      idle(1);
      total++;
      if (bus.field_sel !== 2'd0 || bus.stop !== 1'b0 ||
          bus.blink !== 1'b1 || bus.cnt_clk !== 1'b0 ||
          {bus.adjust_h, bus.adjust_m, bus.adjust_s} !== 3'b000) begin
         bad++; $display("FAIL rmid_out fsel=%0d stop=%b blink=%b cnt=%b adj=%b want 0/0/1/0/000",
                         bus.field_sel, bus.stop, bus.blink, bus.cnt_clk,
                         {bus.adjust_h, bus.adjust_m, bus.adjust_s});
      end
      rst = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 5) begin
            total++;
            if (bus.field_sel !== 2'd0) begin
               bad++; $display("FAIL rmid_early got=%0d want=0",
                               bus.field_sel);
            end
         end
      end
      total++;
      if (bus.field_sel !== 2'd1) begin
         bad++; $display("FAIL rmid_press got=%0d want=1", bus.field_sel);
      end
      bus.key_mode = 1'b0;
      idle(10);
   endtask

   initial begin
      test_reset();
      test_run();
      test_debounce();
      test_cycle();
      test_inc();
      test_autorepeat();
      test_simul();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
